// File: rtl/pipe_reg_chain.sv
// Pipeline register chain with per-stage stall, flush and bubble insertion.
// Also counts retired and squashed items.
module pipe_reg_chain #(
    parameter int STAGES = 4,
    parameter int W      = 64,
    parameter int CNT_W  = 32,
    parameter int OCC_W  = $clog2(STAGES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [W-1:0]          in_data,
    output logic                  in_ready,
    input  logic [STAGES-1:0]     stall,
    input  logic [STAGES-1:0]     flush,
    output logic [STAGES*W-1:0]   stage_data,
    output logic [STAGES-1:0]     stage_valid,
    output logic [OCC_W-1:0]      occupancy,
    output logic [CNT_W-1:0]      retired_cnt,
    output logic [CNT_W-1:0]      squashed_cnt
);

    logic [STAGES-1:0]         valid;
    logic [STAGES-1:0][W-1:0]  data;
    logic [STAGES-1:0]         frozen;
    logic [STAGES-1:0]         up_frozen;
    logic [STAGES-1:0]         prev_valid;
    logic [STAGES-1:0][W-1:0]  prev_data;
    logic [CNT_W-1:0]          ret_q;
    logic [CNT_W-1:0]          sq_q;
    logic [CNT_W-1:0]          sq_inc;
    logic [OCC_W-1:0]          occ;
    logic                      retire;

    // A stall at stage k freezes k and everything upstream of it.
    always_comb begin
        logic f;
        frozen = '0;
        for (int k = 0; k < STAGES; k++) begin
            f = 1'b0;
            for (int j = 0; j < STAGES; j++) begin
                if (j >= k) f = f | stall[j];
            end
            frozen[k] = f;
        end
    end

    always_comb begin
        up_frozen     = '0;
        prev_valid    = '0;
        prev_data     = '0;
        prev_valid[0] = in_valid;
        prev_data[0]  = in_data;
        for (int k = 1; k < STAGES; k++) begin
            up_frozen[k]  = frozen[k-1];
            prev_valid[k] = valid[k-1];
            prev_data[k]  = data[k-1];
        end
    end

    always_comb begin
        sq_inc = '0;
        occ    = '0;
        for (int k = 0; k < STAGES; k++) begin
            sq_inc = sq_inc + CNT_W'(valid[k] & flush[k]);
            occ    = occ + OCC_W'(valid[k]);
        end
    end

    assign retire = valid[STAGES-1] & ~stall[STAGES-1] & ~flush[STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            data  <= '0;
            ret_q <= '0;
            sq_q  <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (flush[k] || (!frozen[k] && up_frozen[k])) begin
                    valid[k] <= 1'b0;
                    data[k]  <= '0;
                end else if (!frozen[k]) begin
                    valid[k] <= prev_valid[k];
                    data[k]  <= prev_data[k];
                end
            end
            ret_q <= ret_q + CNT_W'(retire);
            sq_q  <= sq_q + sq_inc;
        end
    end

    assign in_ready     = ~frozen[0];
    assign stage_data   = data;
    assign stage_valid  = valid;
    assign occupancy    = occ;
    assign retired_cnt  = ret_q;
    assign squashed_cnt = sq_q;

endmodule
